// File: rtl/cdc_req_ack_tx.sv
// cdc_req_ack_tx: source-domain half of a 4-phase req/ack handshake that
// carries one DATA_W word across a clock-domain boundary.
//
// Ports (all in the wr_clk domain except xfer_ack):
//   wr_clk       source clock (the only clock)
//   wr_reset     synchronous active-high reset
//   wr_data      word to transfer
//   wr_valid     wr_data is valid
//   wr_ready     block can accept a word this cycle (decoded from registers)
//   xfer_req     registered request level to the destination domain
//   xfer_data    registered word, stable while xfer_req is high
//   xfer_ack     asynchronous acknowledge from the destination domain
//   done         one-cycle pulse when the synchronized ack is observed
//   busy         high while a handshake is in flight
//   err_timeout  sticky flag: a handshake phase lasted TIMEOUT_CYC cycles
//   xfer_count   completed transfers, wraps
//
// SYNC_STAGES must be at least 2. TIMEOUT_CYC = 0 disables the timeout check.
module cdc_req_ack_tx #(
  parameter int unsigned DATA_W      = 8,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT_CYC = 1024,
  parameter int unsigned COUNT_W     = 16
) (
  input  logic               wr_clk,
  input  logic               wr_reset,
  input  logic [DATA_W-1:0]  wr_data,
  input  logic               wr_valid,
  output logic               wr_ready,
  output logic               xfer_req,
  output logic [DATA_W-1:0]  xfer_data,
  input  logic               xfer_ack,
  output logic               done,
  output logic               busy,
  output logic               err_timeout,
  output logic [COUNT_W-1:0] xfer_count
);

  localparam int unsigned TMO_W  = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC + 1);
  localparam bit          TMO_EN = (TIMEOUT_CYC != 0);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t               r_state;
  logic                 r_req;
  logic [DATA_W-1:0]    r_data;
  logic                 r_done;
  logic [COUNT_W-1:0]   r_count;
  logic [SYNC_STAGES-1:0] r_ack_sync;
  logic [TMO_W-1:0]     r_tmo_cnt;
  logic                 r_err;

  logic                 w_ack_s;
  logic                 w_ready;
  logic                 w_state_chg;

  // Ack synchronizer; resets to 1s so nothing is accepted until a clean
  // low level from the destination has propagated through every stage.
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      r_ack_sync <= '1;
    end else begin
      r_ack_sync <= {r_ack_sync[SYNC_STAGES-2:0], xfer_ack};
    end
  end

  assign w_ack_s = r_ack_sync[SYNC_STAGES-1];

  // Ready is a pure register decode; it never looks at wr_valid.
  assign w_ready = (r_state == ST_IDLE) && !w_ack_s;

  // Mirrors the FSM transition conditions so the phase timer can restart.
  always_comb begin
    w_state_chg = 1'b0;
    case (r_state)
      ST_IDLE: w_state_chg = wr_valid && w_ready;
      ST_REQ:  w_state_chg = w_ack_s;
      ST_DROP: w_state_chg = !w_ack_s;
      default: w_state_chg = 1'b1;
    endcase
  end

  // Handshake FSM: IDLE -> REQ (raise req) -> DROP (wait ack low) -> IDLE.
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      r_state <= ST_IDLE;
      r_req   <= 1'b0;
      r_data  <= '0;
      r_done  <= 1'b0;
      r_count <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (wr_valid && w_ready) begin
            r_data  <= wr_data;
            r_req   <= 1'b1;
            r_state <= ST_REQ;
          end
        end
        ST_REQ: begin
          // A low ack_s here is simply waited out, so an early glitch low is ignored.
          if (w_ack_s) begin
            r_req   <= 1'b0;
            r_done  <= 1'b1;
            r_count <= r_count + COUNT_W'(1);
            r_state <= ST_DROP;
          end
        end
        ST_DROP: begin
          if (!w_ack_s) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_req   <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Phase timer: counts cycles spent in REQ/DROP, restarts on every state
  // change, saturates at TIMEOUT_CYC. The handshake is never aborted.
  always_ff @(posedge wr_clk) begin
    if (wr_reset) begin
      r_tmo_cnt <= '0;
      r_err     <= 1'b0;
    end else begin
      if (w_state_chg || (r_state == ST_IDLE)) begin
        r_tmo_cnt <= '0;
      end else if (r_tmo_cnt != TMO_W'(TIMEOUT_CYC)) begin
        r_tmo_cnt <= r_tmo_cnt + TMO_W'(1);
      end
      if (TMO_EN && !w_state_chg && (r_state != ST_IDLE) &&
          (r_tmo_cnt == TMO_W'(TIMEOUT_CYC - 1))) begin
        r_err <= 1'b1;
      end
    end
  end

  assign wr_ready    = w_ready;
  assign xfer_req    = r_req;
  assign xfer_data   = r_data;
  assign done        = r_done;
  assign busy        = (r_state != ST_IDLE);
  assign err_timeout = r_err;
  assign xfer_count  = r_count;

endmodule
